// File: rtl/seg7_scan_2digit_if.sv
// Display-side bundle for seg7_scan_2digit: value load in, multiplexed segment/anode pins out.
// master = the core that supplies values, slave = the scan driver.
interface seg7_scan_2digit_if;
   logic       load;
   logic [3:0] value_in;
   logic [6:0] outDisplay;
   logic       an3;
   logic       an4;
   logic       frame;

   modport master (
      output load,
      output value_in,
      input  outDisplay,
      input  an3,
      input  an4,
      input  frame
   );

   modport slave (
      input  load,
      input  value_in,
      output outDisplay,
      output an3,
      output an4,
      output frame
   );
endinterface

// File: rtl/seg7_scan_2digit.sv
// Latches a 4-bit value and scans its tens/units digits onto one active-low 7-seg bus.
// Latency: 1 cycle from (state, cnt, value_q) to the pins; a load is visible on the edge after capture.
// No backpressure: load is level-sensitive and captured on every edge where it is high.
module seg7_scan_2digit #(
   parameter int REFRESH_DIV = 50000,
   parameter int GUARD       = 2,
   parameter bit BLANK_LZ    = 1'b1
) (
   input logic               clk,
   input logic               rst,
   seg7_scan_2digit_if.slave bus
);
   localparam int            CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
   localparam logic [6:0]    SEG_BLANK = 7'b1111111;

   typedef enum logic {S_UNITS, S_TENS} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [3:0]    value_q;
   logic          scan_done;
   logic [6:0]    seg_q;
   logic          an3_q;
   logic          an4_q;
   logic          frame_q;

   logic          tens;
   logic [3:0]    units;
   logic [6:0]    units_seg;
   logic [6:0]    tens_seg;
   logic [6:0]    seg_d;
   logic          an3_d;
   logic          an4_d;
   logic          wrap;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    seg_decode = 7'b0000001;
         4'd1:    seg_decode = 7'b1001111;
         4'd2:    seg_decode = 7'b0010010;
         4'd3:    seg_decode = 7'b0000110;
         4'd4:    seg_decode = 7'b1001100;
         4'd5:    seg_decode = 7'b0100100;
         4'd6:    seg_decode = 7'b0100000;
         4'd7:    seg_decode = 7'b0001111;
         4'd8:    seg_decode = 7'b0000000;
         4'd9:    seg_decode = 7'b0000100;
         default: seg_decode = SEG_BLANK;
      endcase
   endfunction

   always_comb begin
      tens      = (value_q >= 4'd10);
      units     = tens ? (value_q - 4'd10) : value_q;
      units_seg = seg_decode(units);
      tens_seg  = tens ? seg_decode(4'd1) : (BLANK_LZ ? SEG_BLANK : seg_decode(4'd0));
      wrap      = (cnt == CNT_MAX);

      // Both anodes stay off for the first GUARD cycles of a slot so the
      // previous digit's segments never ghost onto the new anode.
      seg_d = SEG_BLANK;
      an3_d = 1'b1;
      an4_d = 1'b1;
      if (cnt >= CNT_GUARD) begin
         if (state == S_UNITS) begin
            an4_d = 1'b0;
            seg_d = units_seg;
         end else begin
            an3_d = 1'b0;
            seg_d = tens_seg;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_UNITS;
         cnt       <= '0;
         value_q   <= 4'd0;
         scan_done <= 1'b0;
         seg_q     <= SEG_BLANK;
         an3_q     <= 1'b1;
         an4_q     <= 1'b1;
         frame_q   <= 1'b0;
      end else begin
         if (bus.load) begin
            value_q <= bus.value_in;
         end
         cnt <= wrap ? '0 : cnt + 1'b1;
         case (state)
            S_UNITS: if (wrap) state <= S_TENS;
            S_TENS:  if (wrap) state <= S_UNITS;
            default: state <= S_UNITS;
         endcase
         // Delayed one stage so frame lines up with the registered pins.
         scan_done <= wrap && (state == S_TENS);
         frame_q   <= scan_done;
         seg_q     <= seg_d;
         an3_q     <= an3_d;
         an4_q     <= an4_d;
      end
   end

   assign bus.outDisplay = seg_q;
   assign bus.an3        = an3_q;
   assign bus.an4        = an4_q;
   assign bus.frame      = frame_q;
endmodule

// File: tb/tb_seg7_scan_2digit.sv
// Scoreboard bench for seg7_scan_2digit at REFRESH_DIV=8, GUARD=2, with leading-zero blanking on and off.
module tb_seg7_scan_2digit;
   localparam int RDIV  = 8;
   localparam int GRD   = 2;
   localparam int PER   = 2 * RDIV;

   logic       clk;
   logic       rst;
   logic       load;
   logic [3:0] value_in;

   seg7_scan_2digit_if bus_b ();
   seg7_scan_2digit_if bus_z ();

   assign bus_b.load     = load;
   assign bus_b.value_in = value_in;
   assign bus_z.load     = load;
   assign bus_z.value_in = value_in;

   seg7_scan_2digit #(.REFRESH_DIV(RDIV), .GUARD(GRD), .BLANK_LZ(1'b1)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   seg7_scan_2digit #(.REFRESH_DIV(RDIV), .GUARD(GRD), .BLANK_LZ(1'b0)) dut_z (
      .clk (clk),
      .rst (rst),
      .bus (bus_z)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [6:0] seg_b;
      logic [6:0] seg_z;
      logic       an3;
      logic       an4;
      logic       frame;
   } exp_t;

   exp_t       exp_q[$];
   int         n_chk  = 0;
   int         n_pass = 0;
   int         mk     = 0;
   logic [3:0] mval   = 4'd0;
   bit         started = 1'b0;

   task automatic check(input string tag, input logic [6:0] got, input logic [6:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %b want %b at %0t", tag, got, want, $time);
   endtask

   // Digit patterns written out independently of the design; 10 means blank.
   function automatic logic [6:0] pat(input int d);
      case (d)
         0: return 7'b0000001;
         1: return 7'b1001111;
         2: return 7'b0010010;
         3: return 7'b0000110;
         4: return 7'b1001100;
         5: return 7'b0100100;
         6: return 7'b0100000;
         7: return 7'b0001111;
         8: return 7'b0000000;
         9: return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   // Reference model: mk counts edges since reset release (E1 = first), position from mk alone.
   initial begin
      exp_t e;
      int   s, t, u;
      forever begin
         @(posedge clk);
         e = '{seg_b: 7'b1111111, seg_z: 7'b1111111, an3: 1'b1, an4: 1'b1, frame: 1'b0};
         if (rst) begin
            started = 1'b1;
            mk      = 0;
            mval    = 4'd0;
         end else if (started) begin
            mk++;
            s = (mk - 1) % PER;
            t = int'(mval) / 10;
            u = int'(mval) % 10;
            if ((s % RDIV) >= GRD) begin
               if (s < RDIV) begin
                  e.an4   = 1'b0;
                  e.seg_b = pat(u);
                  e.seg_z = pat(u);
               end else begin
                  e.an3   = 1'b0;
                  e.seg_b = (t != 0) ? pat(t) : pat(10);
                  e.seg_z = pat(t);
               end
            end
            e.frame = (mk > PER) && ((mk - 1) % PER == 0);
            if (load) mval = value_in;
         end
         if (started) exp_q.push_back(e);
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("seg_blank", bus_b.outDisplay, e.seg_b);
            check("seg_zero",  bus_z.outDisplay, e.seg_z);
            check("an3",       {6'd0, bus_b.an3}, {6'd0, e.an3});
            check("an4",       {6'd0, bus_b.an4}, {6'd0, e.an4});
            check("frame",     {6'd0, bus_b.frame}, {6'd0, e.frame});
            check("an_overlap", {6'd0, ~bus_b.an3 & ~bus_b.an4}, 7'd0);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_load(input logic [3:0] v);
      load     = 1'b1;
      value_in = v;
      tick(1);
      load     = 1'b0;
      value_in = 4'bxxxx;
   endtask

   // Bounded wait until the next edge lands on slot position pos.
   task automatic wait_pos(input int pos);
      int n = 0;
      while ((mk % PER) != pos && n < 2 * PER) begin
         tick(1);
         n++;
      end
      check("wait_pos", {6'd0, (mk % PER) == pos}, 7'd1);
   endtask

   initial begin
      rst      = 1'b1;
      load     = 1'b0;
      value_in = 4'bxxxx;
      tick(2);
      rst = 1'b0;
      tick(PER + 4);

      do_load(4'd11);
      tick(2 * PER);
      do_load(4'd7);
      tick(2 * PER);

      for (int v = 0; v < 16; v++) begin
         do_load(4'(v));
         tick(PER - 1 + (v % 3));
      end

      wait_pos(3);
      do_load(4'd15);
      tick(1);
      do_load(4'd3);
      tick(PER);

      // Load landing exactly on the slot wrap edge.
      wait_pos(RDIV - 1);
      do_load(4'd13);
      tick(PER);

      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            load     = 1'b1;
            value_in = 4'($urandom_range(0, 15));
         end else begin
            load     = 1'b0;
            value_in = 4'bxxxx;
         end
         tick(1);
      end
      load     = 1'b0;
      value_in = 4'bxxxx;

      do_load(4'd12);
      wait_pos(RDIV + 3);
      rst  = 1'b1;
      load = 1'b1;
      value_in = 4'd9;
      tick(1);
      rst  = 1'b0;
      load = 1'b0;
      value_in = 4'bxxxx;
      check("value_q_rst", {3'd0, dut_b.value_q}, 7'd0);
      tick(2 * PER);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/seg7_scan_2digit.md
# seg7_scan_2digit

Downstream display stage for the 4-bit datapath. It latches a 4-bit binary result, splits it into tens and units decimal digits (0–15), and time-multiplexes them onto one shared active-low 7-segment bus with two active-low anode enables (an3 = tens, an4 = units). It includes a ghosting guard and a frame pulse, and sits between the register/counter core and the board's display pins.

## Interface
- REFRESH_DIV, 50000: clock cycles each digit slot lasts. Must be ≥ 4.
- GUARD, 2: cycles at the start of each slot with both anodes off. Must be ≥ 1 and < REFRESH_DIV.
- BLANK_LZ, 1: when 1, the tens digit is blanked when the value is below 10.
- One clock; reset is synchronous and active-high. The ports are `clk` and `rst`.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  when high, value_in is captured at the next edge.
- value_in  in  4  unsigned binary value, 0–15.
- outDisplay  out  7  segments, active-low; bit 6 = a … bit 0 = g.
- an3  out  1  tens-digit anode, active-low.
- an4  out  1  units-digit anode, active-low.
- frame  out  1  one-cycle pulse when a full units+tens scan completes.

## Operation
- Value register value_q:
  - Reset: 0.
  - load=1: value_q ← value_in. Otherwise it holds.
  - load is level-sensitive; holding it high re-captures every cycle.
- Digit split (combinational from value_q):
  - tens = (value_q ≥ 10).
  - units = value_q − 10·tens.
- Decoder, active-low, a..g:
  - 0 → 0000001, 1 → 1001111, 2 → 0010010, 3 → 0000110, 4 → 1001100
  - 5 → 0100100, 6 → 0100000, 7 → 0001111, 8 → 0000000, 9 → 0000100
  - blank → 1111111
- Tens digit when tens = 0: blank if BLANK_LZ = 1, otherwise pattern "0".
- Slot counter cnt:
  - Range 0..REFRESH_DIV−1; reset value 0.
  - Increments every cycle and wraps to 0 after REFRESH_DIV−1.
- State machine, two states; reset state S_UNITS:
  - S_UNITS → S_TENS when cnt wraps.
  - S_TENS → S_UNITS when cnt wraps.
  - No other transitions.
- Output decode, computed from (state, cnt, value_q) and then registered:
  - cnt < GUARD: an3 = an4 = 1, outDisplay = 1111111.
  - S_UNITS with cnt ≥ GUARD: an4 = 0, an3 = 1, outDisplay = units pattern.
  - S_TENS with cnt ≥ GUARD: an3 = 0, an4 = 1, outDisplay = tens pattern.
- an3 and an4 are never low in the same cycle, under any input sequence.
- frame is registered. It is high for exactly one cycle, following the edge on which state is S_TENS and cnt wraps.

## Timing
- Reset values while rst=1 and on the edge after rst falls: outDisplay = 1111111, an3 = 1, an4 = 1, frame = 0, value_q = 0, cnt = 0, state = S_UNITS.
- rst asserted mid-scan: all of the above are restored on the next edge. Any pending load in that same cycle is ignored.
- Output latency is 1 cycle from (state, cnt, value_q) to the pins.
- load → display latency:
  - load sampled at edge N, value_q updated at N, visible on outDisplay at edge N+1, if a digit is active.
  - The scan is not restarted and the slot position does not change.
- Scan period: 2·REFRESH_DIV cycles. Each anode is low for REFRESH_DIV − GUARD consecutive cycles per period.
- Example, REFRESH_DIV=8, GUARD=2, first rising edge with rst=0 is E1:
  - an4 low after E3 through E8.
  - Both anodes off after E9 and E10.
  - an3 low after E11 through E16.
  - frame high after E17 only.
  - The pattern repeats with period 16.
- load in the same cycle as a slot wrap: the new value is used for the new slot's first visible cycle. No stale-digit cycle occurs.
- value_in only matters when load=1. Any X on value_in while load=0 must not propagate.

## Test plan
- Reset/startup (REFRESH_DIV=8, GUARD=2): pulse rst for 2 cycles → outputs all-off during reset and 2 cycles after. an4 falls at E3, and outDisplay = 0000001 with tens blanked.
- Load 4'b1011 (11) → while an4=0, outDisplay = 1001111 ("1"); while an3=0, outDisplay = 1001111 ("1"). frame pulses once every 16 cycles.
- Load 7 with BLANK_LZ=1 → units slot shows 0001111; tens slot shows 1111111 with an3=0. Repeat with BLANK_LZ=0 → tens slot shows 0000001.
- Sweep value_in 0–15, one load per scan period → each tens/units pattern matches the table. The checker asserts an3 and an4 are never both low over 10,000 cycles of random loads.
- Load 15 then 3 mid-way through the units slot → outDisplay changes from 0100100 to 0000110 exactly 1 cycle after the load edge. cnt and the anode timing are unchanged.
- Assert rst mid-way through the tens slot with value 12 → on the next edge all outputs are off and value_q = 0. After release, the units slot shows "0" and the scan restarts at S_UNITS, cnt=0.
